// File: rtl/string_fifo_loader.sv
// string_fifo_loader: copies word_count 32-bit words from a contiguous source
// region into a string FIFO slave's data register over an Avalon-MM master.
// Latency: with zero wait states each word costs one RD plus one WR cycle; an
// accepted command adds one FIN cycle (and one FLUSH write when
// STRING_LOADER_FLUSH_EN is defined). Backpressure: every bus phase holds its
// address/control/data steady while avm_waitrequest is high.
//
// Ports:
//   clk, reset (async, active low)    -- clock and block reset
//   start, src_addr, dst_addr,        -- command strobe and operands, only
//   word_count                        --   sampled while idle
//   busy, done, error                 -- status: not idle / completion pulse /
//                                     --   reject pulse (count too large)
//   avm_*                             -- Avalon-MM master port
//
// Build option: define STRING_LOADER_FLUSH_EN to clear the target FIFO (write 0
// to its status/clear register) before every accepted non-empty transfer.
// Without it the words are appended to whatever the FIFO already holds.

module string_fifo_loader #(
    parameter int MAX_WORDS       = 8,
    parameter int FIFO_STATUS_OFS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [3:0]  word_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam logic [31:0] MAX_W    = 32'(MAX_WORDS);
    localparam logic [31:0] STAT_OFS = 32'(FIFO_STATUS_OFS);

`ifdef STRING_LOADER_FLUSH_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_RD    = 3'd2,
        S_WR    = 3'd3,
        S_FIN   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd2,
        S_WR    = 3'd3,
        S_FIN   = 3'd4
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] src_q,   src_d;     // source pointer, wraps modulo 2^32
    logic [31:0] dst_q,   dst_d;     // FIFO data register address
    logic [3:0]  rem_q,   rem_d;     // words still to move
    logic [31:0] data_q,  data_d;    // word in flight between RD and WR
    logic        err_q,   err_d;

    logic        cnt_too_big;
    logic        cnt_zero;

    assign cnt_too_big = {28'd0, word_count} > MAX_W;
    assign cnt_zero    = (word_count == 4'd0);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            src_q   <= 32'd0;
            dst_q   <= 32'd0;
            rem_q   <= 4'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        data_d  = data_q;
        err_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Operands are captured on every start, including rejected
                // ones; a rejected command simply never leaves IDLE.
                if (start) begin
                    src_d = src_addr;
                    dst_d = dst_addr;
                    rem_d = word_count;
                    if (cnt_too_big) begin
                        err_d = 1'b1;
                    end else if (cnt_zero) begin
                        state_d = S_FIN;
                    end else begin
`ifdef STRING_LOADER_FLUSH_EN
                        state_d = S_FLUSH;
`else
                        state_d = S_RD;
`endif
                    end
                end
            end

`ifdef STRING_LOADER_FLUSH_EN
            S_FLUSH: begin
                if (!avm_waitrequest) begin
                    state_d = S_RD;
                end
            end
`endif

            S_RD: begin
                if (!avm_waitrequest) begin
                    data_d  = avm_readdata;
                    state_d = S_WR;
                end
            end

            S_WR: begin
                if (!avm_waitrequest) begin
                    src_d   = src_q + 32'd4;
                    rem_d   = rem_q - 4'd1;
                    // rem_q==1 means this write was the last word
                    state_d = (rem_q == 4'd1) ? S_FIN : S_RD;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only, so they cannot move
    // while waitrequest stalls a phase and drop to 0 the instant reset
    // forces IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        avm_address   = 32'd0;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_writedata = 32'd0;

        unique case (state_q)
`ifdef STRING_LOADER_FLUSH_EN
            S_FLUSH: begin
                avm_write   = 1'b1;
                avm_address = dst_q + STAT_OFS;
            end
`endif
            S_RD: begin
                avm_read    = 1'b1;
                avm_address = src_q;
            end
            S_WR: begin
                avm_write     = 1'b1;
                avm_address   = dst_q;
                avm_writedata = data_q;
            end
            default: begin
                avm_address   = 32'd0;
            end
        endcase
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_FIN);
    assign error = err_q;

endmodule

// File: tb/tb_string_fifo_loader.sv
module tb_string_fifo_loader;

`ifdef STRING_LOADER_FLUSH_EN
    localparam int FL = 1;
`else
    localparam int FL = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [3:0]  word_count;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    string_fifo_loader #(.MAX_WORDS(8), .FIFO_STATUS_OFS(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .src_addr        (src_addr),
        .dst_addr        (dst_addr),
        .word_count      (word_count),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // bus responder / observation state
    int          wait_n;
    int          wait_cnt;
    bit          wait_pend;
    logic [31:0] hold_addr, hold_wdata;
    logic        hold_rd, hold_wr;
    int          step_no;
    int          done_cnt, done_step, err_cnt, err_step;
    int          log_n;
    logic        log_wr   [64];
    logic [31:0] log_addr [64];
    logic [31:0] log_data [64];
    int          wr_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_0100: mem_rd = 32'h6463_6261;
            32'h0000_0104: mem_rd = 32'h6867_6665;
            32'h0000_0108: mem_rd = 32'h0000_6A69;
            default:       mem_rd = a ^ 32'hA5A5_0000;
        endcase
    endfunction

    task automatic clear_log();
        step_no = 0; done_cnt = 0; done_step = 0; err_cnt = 0; err_step = 0;
        log_n = 0; wr_cnt = 0; wait_cnt = 0; wait_pend = 0;
    endtask

    // One clock: observe at the falling edge, then answer the bus.
    task automatic step();
        @(negedge clk);
        step_no++;
        if (wait_pend) begin
            check("hold_addr",  avm_address,   hold_addr);
            check("hold_rd",    {31'd0, avm_read},  {31'd0, hold_rd});
            check("hold_wr",    {31'd0, avm_write}, {31'd0, hold_wr});
            check("hold_wdata", avm_writedata, hold_wdata);
        end
        check("rd_wr_excl", {31'd0, avm_read & avm_write}, 32'd0);
        if (done) begin
            done_cnt++;
            if (done_step == 0) done_step = step_no;
        end
        if (error) begin
            err_cnt++;
            if (err_step == 0) err_step = step_no;
        end
        if (avm_read || avm_write) begin
            avm_readdata = avm_read ? mem_rd(avm_address) : 32'd0;
            if (wait_cnt < wait_n) begin
                avm_waitrequest = 1'b1;
                wait_cnt++;
                wait_pend  = 1;
                hold_addr  = avm_address;
                hold_rd    = avm_read;
                hold_wr    = avm_write;
                hold_wdata = avm_writedata;
            end else begin
                avm_waitrequest = 1'b0;
                wait_cnt  = 0;
                wait_pend = 0;
                if (log_n < 64) begin
                    log_wr[log_n]   = avm_write;
                    log_addr[log_n] = avm_address;
                    log_data[log_n] = avm_write ? avm_writedata : avm_readdata;
                    log_n++;
                end
                if (avm_write) wr_cnt++;
            end
        end else begin
            avm_waitrequest = 1'b0;
            avm_readdata    = 32'd0;
            wait_cnt  = 0;
            wait_pend = 0;
        end
    endtask

    task automatic start_cmd(input logic [31:0] s, input logic [31:0] d, input logic [3:0] n);
        clear_log();
        src_addr = s; dst_addr = d; word_count = n; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to(input int last_step);
        while (step_no < last_step) step();
    endtask

    task automatic check_entry(input string tag, input int idx, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data);
        check({tag, "_kind"}, {31'd0, log_wr[idx]}, {31'd0, wr});
        check({tag, "_addr"}, log_addr[idx], addr);
        if (wr) check({tag, "_data"}, log_data[idx], data);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; src_addr = 32'd0; dst_addr = 32'd0;
        word_count = 4'd0; avm_readdata = 32'd0; avm_waitrequest = 1'b0;
        wait_n = 0;
        clear_log();
        #1;
        // ---- reset state ----
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_rd",    {31'd0, avm_read},  32'd0);
        check("rst_wr",    {31'd0, avm_write}, 32'd0);
        check("rst_addr",  avm_address,   32'd0);
        check("rst_wdata", avm_writedata, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        step();

        // ---- basic 3-word copy, no wait states ----
        start_cmd(32'h100, 32'h2000, 4'd3);
        check("s1_busy", {31'd0, busy}, 32'd1);
        run_to(12);
        check("s1_nlog", log_n, 6 + FL);
`ifdef STRING_LOADER_FLUSH_EN
        check_entry("s1_flush", 0, 1'b1, 32'h2008, 32'd0);
`endif
        check_entry("s1_r0", FL + 0, 1'b0, 32'h100,  32'd0);
        check_entry("s1_w0", FL + 1, 1'b1, 32'h2000, 32'h6463_6261);
        check_entry("s1_r1", FL + 2, 1'b0, 32'h104,  32'd0);
        check_entry("s1_w1", FL + 3, 1'b1, 32'h2000, 32'h6867_6665);
        check_entry("s1_r2", FL + 4, 1'b0, 32'h108,  32'd0);
        check_entry("s1_w2", FL + 5, 1'b1, 32'h2000, 32'h0000_6A69);
        check("s1_done_cnt",  done_cnt,  1);
        check("s1_done_step", done_step, 7 + FL);
        check("s1_err_cnt",   err_cnt,   0);
        check("s1_idle",      {31'd0, busy}, 32'd0);

        // ---- two wait states on every access ----
        wait_n = 2;
        start_cmd(32'h200, 32'h3000, 4'd2);
        run_to(24);
        wait_n = 0;
        check("s2_nlog", log_n, 4 + FL);
`ifdef STRING_LOADER_FLUSH_EN
        check_entry("s2_flush", 0, 1'b1, 32'h3008, 32'd0);
`endif
        check_entry("s2_r0", FL + 0, 1'b0, 32'h200,  32'd0);
        check_entry("s2_w0", FL + 1, 1'b1, 32'h3000, 32'hA5A5_0200);
        check_entry("s2_r1", FL + 2, 1'b0, 32'h204,  32'd0);
        check_entry("s2_w1", FL + 3, 1'b1, 32'h3000, 32'hA5A5_0204);
        check("s2_done_cnt",  done_cnt,  1);
        check("s2_done_step", done_step, 3 * (4 + FL) + 1);

        // ---- count above limit: error only ----
        start_cmd(32'h100, 32'h2000, 4'd9);
        run_to(5);
        check("s3_err_cnt",  err_cnt,  1);
        check("s3_err_step", err_step, 1);
        check("s3_nlog",     log_n,    0);
        check("s3_done_cnt", done_cnt, 0);

        // ---- zero count: done only ----
        start_cmd(32'h100, 32'h2000, 4'd0);
        run_to(5);
        check("s4_done_cnt",  done_cnt,  1);
        check("s4_done_step", done_step, 1);
        check("s4_nlog",      log_n,     0);
        check("s4_err_cnt",   err_cnt,   0);

        // ---- start while busy is ignored ----
        start_cmd(32'h400, 32'h4000, 4'd8);
        step(); step();
        src_addr = 32'h900; dst_addr = 32'h9000; word_count = 4'd3; start = 1'b1;
        step(); step(); step();
        start = 1'b0;
        run_to(30);
        check("s5_nlog",     log_n,    16 + FL);
        check("s5_wr_cnt",   wr_cnt,   8 + FL);
        check("s5_done_cnt", done_cnt, 1);
        check_entry("s5_r7", FL + 14, 1'b0, 32'h41C,  32'd0);
        check_entry("s5_w7", FL + 15, 1'b1, 32'h4000, 32'hA5A5_041C);

        // ---- reset during WR of word 2 ----
        start_cmd(32'h500, 32'h5000, 4'd3);
        run_to(4 + FL);
        check("s6_in_wr",  {31'd0, avm_write}, 32'd1);
        check("s6_waddr",  avm_address,   32'h5000);
        check("s6_wdata",  avm_writedata, 32'hA5A5_0504);
        reset = 1'b0;
        #1;
        check("s6_busy0",  {31'd0, busy},      32'd0);
        check("s6_wr0",    {31'd0, avm_write}, 32'd0);
        check("s6_rd0",    {31'd0, avm_read},  32'd0);
        check("s6_addr0",  avm_address,        32'd0);
        check("s6_wdata0", avm_writedata,      32'd0);
        check("s6_done0",  {31'd0, done},      32'd0);
        done_cnt = 0;
        step(); step(); step();
        check("s6_no_done", done_cnt, 0);
        reset = 1'b1;
        step();
        start_cmd(32'h600, 32'h6000, 4'd1);
        run_to(6);
        check("s6_nlog", log_n, 2 + FL);
        check_entry("s6_r0", FL + 0, 1'b0, 32'h600,  32'd0);
        check_entry("s6_w0", FL + 1, 1'b1, 32'h6000, 32'hA5A5_0600);
        check("s6_done_cnt",  done_cnt,  1);
        check("s6_done_step", done_step, 3 + FL);

        // ---- source pointer wrap ----
        start_cmd(32'hFFFF_FFFC, 32'h7000, 4'd2);
        run_to(10);
        check("s7_nlog", log_n, 4 + FL);
        check_entry("s7_r0", FL + 0, 1'b0, 32'hFFFF_FFFC, 32'd0);
        check_entry("s7_w0", FL + 1, 1'b1, 32'h7000,      32'h5A5A_FFFC);
        check_entry("s7_r1", FL + 2, 1'b0, 32'h0000_0000, 32'd0);
        check_entry("s7_w1", FL + 3, 1'b1, 32'h7000,      32'hA5A5_0000);
        check("s7_done_cnt", done_cnt, 1);
        check("s7_err_cnt",  err_cnt,  0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
